// File: rtl/adder_pkg.sv
// adder_pkg: shared op-mode encoding and per-stage payload for pipelined_adder.
// Payload vectors are sized to ADDER_MAX_W; a pipelined_adder instance uses
// the low WIDTH bits, so WIDTH must not exceed ADDER_MAX_W.
package adder_pkg;

   localparam int ADDER_MAX_W = 64;

   // Operation mode, carried on the 'sub' input.
   typedef enum logic {
      ADD = 1'b0,
      SUB = 1'b1
   } op_mode_e;

   // Everything an operation needs while it walks down the pipeline.
   typedef struct packed {
      logic                   valid;   // stage holds a live operation
      logic [ADDER_MAX_W-1:0] a_rem;   // operand a (slices past this stage still pending)
      logic [ADDER_MAX_W-1:0] b_rem;   // operand b, already inverted for subtract
      logic [ADDER_MAX_W-1:0] sum;     // sum slices finished so far
      logic                   carry;   // carry out of the last finished slice
      logic                   a_sign;  // msb of a, for signed overflow
      logic                   b_sign;  // msb of effective b, for signed overflow
   } stage_t;

endpackage

// File: rtl/adder_stage.sv
// adder_stage: purely combinational CHUNK-bit ripple-carry slice adder.
module adder_stage #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] s,
   output logic         cout
);

   // Ripple the carry bit by bit across the slice.
   always_comb begin
      logic c;
      // NOTE: blocking '=' here is deliberate: c must update within one pass
      // of the loop; sequential state elsewhere uses '<=' only.
      s = '0;
      c = cin;
      for (int i = 0; i < W; i++) begin
         s[i] = a[i] ^ b[i] ^ c;
         c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract split into STAGES ripple slices,
// one slice per pipeline stage, with valid/ready flow control and flush.
// Optional feature: define PIPELINED_ADDER_OVERFLOW_EN to add the 'overflow'
// output (signed two's-complement overflow, aligned with sum).
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_aN,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
`ifdef PIPELINED_ADDER_OVERFLOW_EN
   output logic             cout,
   output logic             overflow
`else
   output logic             cout
`endif
);

   localparam int CHUNK = WIDTH / STAGES;

   logic [STAGES-1:0] valid_vec;
   logic [STAGES-1:0] adv;
   logic [WIDTH-1:0]  b_eff;
   logic              c0;
   stage_t            last_q;

   logic [CHUNK-1:0]  slice_a  [STAGES];
   logic [CHUNK-1:0]  slice_b  [STAGES];
   logic [CHUNK-1:0]  slice_s  [STAGES];
   logic              slice_ci [STAGES];
   logic              slice_co [STAGES];

   // Mode handling at stage 0 entry: subtract is a + ~b + 1, cin ignored.
   always_comb begin
      b_eff = (op_mode_e'(sub) == SUB) ? ~b : b;
      c0    = (op_mode_e'(sub) == SUB) ? 1'b1 : cin;
   end

   // A stage advances when it or any later stage is empty, or the output drains.
   always_comb begin
      adv = '0;
      for (int k = 0; k < STAGES; k++) begin
         adv[k] = out_ready;
         for (int j = k; j < STAGES; j++) begin
            if (!valid_vec[j]) adv[k] = 1'b1;
         end
      end
   end

   assign in_ready = adv[0] && !flush;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      stage_t stage_q;
      stage_t stage_d;

      assign valid_vec[k] = stage_q.valid;

      adder_stage #(.W(CHUNK)) u_slice (
         .a    (slice_a[k]),
         .b    (slice_b[k]),
         .cin  (slice_ci[k]),
         .s    (slice_s[k]),
         .cout (slice_co[k])
      );

      if (k == 0) begin : g_first
         assign slice_a[k]  = a[0 +: CHUNK];
         assign slice_b[k]  = b_eff[0 +: CHUNK];
         assign slice_ci[k] = c0;

         // Stage 0 captures a new operation and its lowest sum slice.
         always_comb begin
            stage_d = stage_q;
            if (adv[k]) begin
               stage_d.valid            = in_valid && in_ready;
               stage_d.a_rem            = ADDER_MAX_W'(a);
               stage_d.b_rem            = ADDER_MAX_W'(b_eff);
               stage_d.sum              = '0;
               stage_d.sum[0 +: CHUNK]  = slice_s[k];
               stage_d.carry            = slice_co[k];
`ifdef PIPELINED_ADDER_OVERFLOW_EN
               stage_d.a_sign           = a[WIDTH-1];
               stage_d.b_sign           = b_eff[WIDTH-1];
`else
               stage_d.a_sign           = 1'b0;
               stage_d.b_sign           = 1'b0;
`endif
            end
            if (flush) stage_d.valid = 1'b0;
         end
      end else begin : g_next
         assign slice_a[k]  = g_stage[k-1].stage_q.a_rem[k*CHUNK +: CHUNK];
         assign slice_b[k]  = g_stage[k-1].stage_q.b_rem[k*CHUNK +: CHUNK];
         assign slice_ci[k] = g_stage[k-1].stage_q.carry;

         // Stage k takes its predecessor's payload and adds slice k.
         always_comb begin
            stage_d = stage_q;
            if (adv[k]) begin
               stage_d                     = g_stage[k-1].stage_q;
               stage_d.sum[k*CHUNK +: CHUNK] = slice_s[k];
               stage_d.carry               = slice_co[k];
            end
            if (flush) stage_d.valid = 1'b0;
         end
      end

      // Pipeline register for stage k.
      always_ff @(posedge clk or negedge rst_aN) begin
         // NOTE: data fields are reset along with valid so sum/cout read zero
         // during reset; these are flops, not a memory, so this is cheap.
         if (!rst_aN) stage_q <= '0;
         else         stage_q <= stage_d;
      end

      if (k == STAGES - 1) begin : g_last
         assign last_q = stage_q;
      end
   end

   // Results come straight from the last pipeline register.
   always_comb begin
      out_valid = last_q.valid;
      sum       = last_q.sum[WIDTH-1:0];
      cout      = last_q.carry;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
      overflow  = (last_q.a_sign == last_q.b_sign) && (sum[WIDTH-1] != last_q.a_sign);
`endif
   end

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed self-checking bench for pipelined_adder
// (WIDTH=32, STAGES=4). Overflow checks compile in with
// PIPELINED_ADDER_OVERFLOW_EN.
module tb_pipelined_adder;

   logic        clk;
   logic        rst_aN;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        cin;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] sum;
   logic        cout;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
   logic        overflow;
`endif

   int checks = 0;
   int errors = 0;

   pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
      .clk       (clk),
      .rst_aN    (rst_aN),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
`ifdef PIPELINED_ADDER_OVERFLOW_EN
      .cout      (cout),
      .overflow  (overflow)
`else
      .cout      (cout)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_ovf(input string tag, input logic exp);
`ifdef PIPELINED_ADDER_OVERFLOW_EN
      check(tag, 64'(overflow), 64'(exp));
`endif
   endtask

   // One isolated operation: latency, result, and no duplicate afterwards.
   task automatic run_single(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                             input logic tcin, input logic tsub,
                             input logic [31:0] es, input logic ec, input logic eo);
      int lat;
      a = ta; b = tb_v; cin = tcin; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 12) begin
         step();
         lat++;
      end
      check({tag, "_latency"}, 64'(lat), 64'd4);
      check({tag, "_sum"}, 64'(sum), 64'(es));
      check({tag, "_cout"}, 64'(cout), 64'(ec));
      check_ovf({tag, "_ovf"}, eo);
      step();
      check({tag, "_drained"}, 64'(out_valid), 64'd0);
   endtask

   logic [31:0] va [8];
   logic [31:0] vb [8];
   logic        accepted;
   logic        saw_valid;
   logic        ready_low_seen;
   int          sent;
   int          got;
   int          cyc;

   initial begin
      // ---------------- reset ----------------
      rst_aN = 1'b0; flush = 1'b0; in_valid = 1'b0; a = '0; b = '0;
      cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
      #1;
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_sum", 64'(sum), 64'd0);
      check("reset_cout", 64'(cout), 64'd0);
      check_ovf("reset_ovf", 1'b0);
      repeat (2) @(posedge clk);
      #3 rst_aN = 1'b1;
      step();
      check("idle_in_ready", 64'(in_ready), 64'd1);

      // ---------------- directed single operations ----------------
      run_single("add_ff_1",     32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
      run_single("add_ripple",   32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
      run_single("sub_5_7",      32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
      run_single("sub_min_1",    32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
      run_single("add_pos_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
      run_single("sub_cin_ign",  32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0);
      run_single("add_mixed",    32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 32'hACF1_3569, 1'b0, 1'b0);

      // ---------------- backpressure: 8 ops, out_ready low cycles 3..9 ----------------
      for (int i = 0; i < 8; i++) begin
         va[i] = 32'h0101_0101 * (i + 1);
         vb[i] = 32'h0000_0F0F * (i + 3);
      end
      sent = 0; got = 0; ready_low_seen = 1'b0;
      cin = 1'b0; sub = 1'b0;
      for (cyc = 0; cyc < 40 && got < 8; cyc++) begin
         in_valid  = (sent < 8);
         a         = va[sent % 8];
         b         = vb[sent % 8];
         out_ready = !(cyc >= 3 && cyc <= 9);
         #1;
         if (!in_ready && !ready_low_seen) begin
            ready_low_seen = 1'b1;
            check("bp_in_ready_low_after", 64'(sent), 64'd4);
         end
         if (out_valid) begin
            check("bp_sum_order", 64'(sum), 64'(va[got] + vb[got]));
            if (out_ready) got++;
         end
         accepted = in_valid && in_ready;
         if (accepted) sent++;
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      check("bp_ready_low_seen", 64'(ready_low_seen), 64'd1);
      check("bp_sent", 64'(sent), 64'd8);
      check("bp_got", 64'(got), 64'd8);
      #1;
      check("bp_no_extra", 64'(out_valid), 64'd0);

      // ---------------- flush with 3 ops in flight ----------------
      step();
      for (int i = 0; i < 3; i++) begin
         a = 32'h0000_1000 + i; b = 32'h0000_0001; in_valid = 1'b1;
         #1;
         check("flush_fill_ready", 64'(in_ready), 64'd1);
         step();
      end
      a = 32'h0000_2222; flush = 1'b1; in_valid = 1'b1;
      #1;
      check("flush_in_ready", 64'(in_ready), 64'd0);
      step();
      flush = 1'b0; in_valid = 1'b0;
      check("flush_out_valid", 64'(out_valid), 64'd0);
      saw_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (out_valid) saw_valid = 1'b1;
      end
      check("flush_nothing_emerges", 64'(saw_valid), 64'd0);
      run_single("after_flush", 32'h0000_0030, 32'h0000_0012, 1'b0, 1'b0, 32'h0000_0042, 1'b0, 1'b0);

      // ---------------- asynchronous reset mid-operation ----------------
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         a = 32'hF000_0000 + i; b = 32'h2000_0001; in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0;
      check("prereset_out_valid", 64'(out_valid), 64'd1);
      check("prereset_sum", 64'(sum), 64'h1000_0001);
      check("prereset_cout", 64'(cout), 64'd1);
      #3 rst_aN = 1'b0;
      #1;
      check("async_rst_out_valid", 64'(out_valid), 64'd0);
      check("async_rst_sum", 64'(sum), 64'd0);
      check("async_rst_cout", 64'(cout), 64'd0);
      check_ovf("async_rst_ovf", 1'b0);
      @(posedge clk);
      #3 rst_aN = 1'b1;
      out_ready = 1'b1;
      step();
      check("post_rst_empty", 64'(out_valid), 64'd0);
      check("post_rst_in_ready", 64'(in_ready), 64'd1);
      run_single("after_reset", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; SHALL be >= 2.
REQ-002 Parameter STAGES, default 4, number of pipeline stages; SHALL be >= 1 and divide WIDTH exactly. CHUNK = WIDTH/STAGES.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_aN  input  1  asynchronous active-low reset.
REQ-005 flush  input  1  synchronous cancel of all in-flight operations.
REQ-006 in_valid  input  1  input operation presented.
REQ-007 in_ready  output  1  block accepts input this cycle.
REQ-008 a, b  input  WIDTH each  operands.
REQ-009 cin  input  1  carry-in; used for add only.
REQ-010 sub  input  1  0 = add (a+b+cin), 1 = subtract (a+~b+1, cin ignored).
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts result this cycle.
REQ-013 sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-014 cout  output  1  raw carry out of bit WIDTH-1.

Function
REQ-015 Stage k SHALL add bit slice [k*CHUNK +: CHUNK], using the carry registered by stage k-1 (stage 0 uses the mode carry-in); unprocessed operand slices and finished sum slices SHALL travel with the operation.
REQ-016 Latency SHALL be exactly STAGES cycles from input handshake (in_valid & in_ready) to out_valid with no backpressure; throughput one op/cycle.
REQ-017 A stage SHALL advance when it is empty or its successor advances; the last stage advances when out_valid & out_ready.
REQ-018 in_ready SHALL equal (stage 0 empty or stage 0 advancing) and not flush; no combinational path from out_ready beyond this chain.
REQ-019 out_valid, sum, cout SHALL hold stable while out_valid & !out_ready.
REQ-020 Operations SHALL exit in acceptance order; none dropped or duplicated, except by flush.
REQ-021 flush SHALL clear every stage valid bit at the next edge; in_valid in a flush cycle is not accepted; out_valid low the cycle after flush.
REQ-022 Subtract SHALL invert all b bits at stage 0 entry; cout for subtract = 1 means no borrow.

Reset
REQ-023 rst_aN low SHALL immediately clear all stage valid bits; out_valid=0, sum=0, cout=0, overflow=0 (when present); in_ready=1 after release.
REQ-024 Reset mid-operation SHALL discard all in-flight ops; first op after release behaves as from idle.

Configuration
REQ-025 Macro PIPELINED_ADDER_OVERFLOW_EN defined: extra output overflow (1 bit) = signed two's-complement overflow of the full WIDTH result, aligned with sum; undefined: port absent, no related logic.

Structure
REQ-026 Shared package adder_pkg SHALL hold the op-mode encoding constants (ADD=0, SUB=1) and the per-stage payload struct typedef (valid, remaining a/b slices, sum so far, carry, overflow sign info).
REQ-027 One sub-module, adder_stage (CHUNK-bit ripple slice adder, combinational), SHALL be instantiated once per stage; only pipeline registers in pipelined_adder.

Verification (WIDTH=32, STAGES=4 unless noted)
REQ-028 a=0x0000_00FF, b=0x0000_0001, cin=0, sub=0, out_ready=1 -> after 4 cycles sum=0x0000_0100, cout=0; carry crosses stage 0/1 boundary.
REQ-029 a=0xFFFF_FFFF, b=0x0000_0000, cin=1 -> sum=0x0000_0000, cout=1 (full ripple through all stages); with macro, overflow=0.
REQ-030 a=5, b=7, sub=1 -> sum=0xFFFF_FFFE, cout=0; a=0x8000_0000, b=1, sub=1 -> sum=0x7FFF_FFFF, overflow=1 (macro defined).
REQ-031 Back-to-back 8 ops with out_ready held 0 for cycles 3-9 -> in_ready deasserts after 4 held, no loss, results emerge in order once out_ready=1.
REQ-032 flush asserted with 3 ops in flight, in_valid=1 same cycle -> next cycle out_valid=0, all 3 and the new op never appear; next accepted op completes in 4 cycles.
REQ-033 rst_aN pulsed low asynchronously (between edges) with ops in flight -> out_valid/sum/cout=0 immediately; STAGES=1 and STAGES=32 builds pass REQ-028.
